// File: rtl/pc_sequencer.sv
// Program counter sequencer for the unicycle MIPS core.
// Chooses the next PC and handles stall, halt and single-level interrupts.
module pc_sequencer #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(4)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] data,
    input  logic             halt_instr,
    input  logic             iret,
    input  logic             irq,
    output logic [WIDTH-1:0] PC,
    output logic [1:0]       MUX_PC,
    output logic [WIDTH-1:0] EPC,
    output logic             irq_enable,
    output logic             irq_ack,
    output logic             halted
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [1:0] SEL_INC = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

    state_t           state;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] seq_target;
    logic [1:0]       seq_sel;
    logic             take_irq;

    assign pc_inc   = PC + WIDTH'(1);
    assign take_irq = irq && irq_enable;

    // Sources overlap, so the order here is the priority.
    always_comb begin
        seq_target = pc_inc;
        seq_sel    = SEL_INC;
        if (jump_reg) begin
            seq_target = data;
            seq_sel    = SEL_JR;
        end else if (jump) begin
            seq_target = address;
            seq_sel    = SEL_J;
        end else if (branch_taken) begin
            seq_target = pc_inc + immediate;
            seq_sel    = SEL_BR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            PC         <= RESET_PC;
            EPC        <= '0;
            MUX_PC     <= SEL_INC;
            irq_enable <= 1'b1;
            irq_ack    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            irq_ack <= 1'b0;
            unique case (state)
                RUN: begin
                    if (stall) begin
                        PC <= PC;
                    end else if (take_irq) begin
                        EPC        <= seq_target;
                        PC         <= IRQ_VECTOR;
                        irq_enable <= 1'b0;
                        irq_ack    <= 1'b1;
                    end else if (iret) begin
                        PC         <= EPC;
                        irq_enable <= 1'b1;
                    end else if (halt_instr) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        PC     <= seq_target;
                        MUX_PC <= seq_sel;
                    end
                end
                HALT: begin
                    // Only an enabled interrupt wakes the core.
                    if (take_irq) begin
                        EPC        <= pc_inc;
                        PC         <= IRQ_VECTOR;
                        irq_enable <= 1'b0;
                        irq_ack    <= 1'b1;
                        state      <= RUN;
                        halted     <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer.
// Each record is one clock of inputs and the outputs expected after it.
module tb_pc_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, stall, branch_taken, jump, jump_reg;
    logic [W-1:0] immediate, address, data;
    logic         halt_instr, iret, irq;
    logic [W-1:0] PC, EPC;
    logic [1:0]   MUX_PC;
    logic         irq_enable, irq_ack, halted;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .jump(jump),
        .jump_reg(jump_reg), .immediate(immediate),
        .address(address), .data(data),
        .halt_instr(halt_instr), .iret(iret), .irq(irq),
        .PC(PC), .MUX_PC(MUX_PC), .EPC(EPC),
        .irq_enable(irq_enable), .irq_ack(irq_ack),
        .halted(halted)
    );

    typedef struct {
        logic         rst, stl, br, j, jr, hlt, irt, rq;
        logic [W-1:0] imm, adr, dat;
        logic [W-1:0] e_pc;
        logic [1:0]   e_mux;
        logic [W-1:0] e_epc;
        logic         e_ien, e_ack, e_hlt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t v(
        input logic rst, stl, br, j, jr, hlt, irt, rq,
        input logic [W-1:0] imm, adr, dat,
        input logic [W-1:0] e_pc, input logic [1:0] e_mux,
        input logic [W-1:0] e_epc,
        input logic e_ien, e_ack, e_hlt);
        vec_t r;
        r.rst = rst; r.stl = stl; r.br = br; r.j = j;
        r.jr = jr; r.hlt = hlt; r.irt = irt; r.rq = rq;
        r.imm = imm; r.adr = adr; r.dat = dat;
        r.e_pc = e_pc; r.e_mux = e_mux; r.e_epc = e_epc;
        r.e_ien = e_ien; r.e_ack = e_ack; r.e_hlt = e_hlt;
        return r;
    endfunction

    task automatic apply(input vec_t x, input string name);
        reset = x.rst; stall = x.stl; branch_taken = x.br;
        jump = x.j; jump_reg = x.jr; halt_instr = x.hlt;
        iret = x.irt; irq = x.rq; immediate = x.imm;
        address = x.adr; data = x.dat;
        @(posedge clock);
        #1;
        checks++;
        if (PC === x.e_pc && MUX_PC === x.e_mux &&
            EPC === x.e_epc && irq_enable === x.e_ien &&
            irq_ack === x.e_ack && halted === x.e_hlt) begin
            passed++;
        end else begin
            $display("FAIL %s: got pc=%h mux=%0d epc=%h ien=%b ack=%b hlt=%b want pc=%h mux=%0d epc=%h ien=%b ack=%b hlt=%b",
                     name, PC, MUX_PC, EPC, irq_enable, irq_ack,
                     halted, x.e_pc, x.e_mux, x.e_epc, x.e_ien,
                     x.e_ack, x.e_hlt);
        end
    endtask

    initial begin
        logic [W-1:0] n5, n2, n1;
        n5 = -32'sd5;
        n2 = -32'sd2;
        n1 = '1;
        //             rst stl br j jr hlt irt rq imm adr dat | pc mux epc ien ack hlt
        vecs.push_back(v(1,0,0,0,0,0,0,0, 0,0,0,     0,0,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,     1,0,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,     2,0,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,     3,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,10,0,    10,2,0,1,0,0));
        vecs.push_back(v(0,0,1,0,0,0,0,0, n5,0,0,    6,1,0,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,'h40,0,  'h40,2,0,1,0,0));
        vecs.push_back(v(0,0,0,1,1,0,0,0, 0,'h40,'h80, 'h80,3,0,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,20,0,    20,2,0,1,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,1,0,0,0,0,0,1, 0,0,0, 20,2,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     4,2,21,0,1,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     5,0,21,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     6,0,21,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1,1, 0,'h99,0,  21,0,21,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     4,0,22,0,1,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,0,     22,0,22,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,30,0,    30,2,22,1,0,0));
        vecs.push_back(v(0,0,0,0,0,1,0,0, 0,0,0,     30,2,22,1,0,1));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,'h55,0,  30,2,22,1,0,1));
        vecs.push_back(v(0,1,0,1,0,0,0,0, 0,'h55,0,  30,2,22,1,0,1));
        vecs.push_back(v(0,0,1,0,0,0,0,0, 3,0,0,     30,2,22,1,0,1));
        vecs.push_back(v(0,0,0,0,1,0,1,0, 0,0,7,     30,2,22,1,0,1));
        vecs.push_back(v(0,1,0,0,0,1,0,0, 0,0,0,     30,2,22,1,0,1));
        vecs.push_back(v(0,1,0,0,0,0,0,1, 0,0,0,     4,2,31,0,1,0));
        vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,0,     31,2,31,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     4,2,32,0,1,0));
        vecs.push_back(v(0,0,0,0,0,1,0,0, 0,0,0,     4,2,32,0,0,1));
        vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,     4,2,32,0,0,1));
        vecs.push_back(v(1,1,0,0,0,0,0,0, 0,0,0,     0,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0,0, 0,n1,0,    n1,2,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,     0,0,0,1,0,0));
        vecs.push_back(v(0,0,1,0,0,0,0,0, n2,0,0,    n1,1,0,1,0,0));
        vecs.push_back(v(0,0,1,0,0,0,0,1, 5,0,0,     4,1,5,0,1,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,     5,0,5,0,0,0));

        foreach (vecs[i])
            apply(vecs[i], $sformatf("vec%0d", i));

        // Stall inside the handler must hold iret off and keep irq masked.
        apply(v(0,1,0,0,0,0,1,1, 0,0,0, 5,0,5,0,0,0), "stall_iret");
        apply(v(0,0,0,0,0,0,1,0, 0,0,0, 5,0,5,1,0,0), "iret_after");
        // Re-enter, then reset mid-handler: EPC must clear.
        apply(v(0,0,0,1,0,0,0,1, 0,9,0, 4,0,9,0,1,0), "irq_jump");
        apply(v(1,0,0,0,0,0,0,1, 0,0,0, 0,0,0,1,0,0), "rst_handler");
        apply(v(0,0,0,0,0,0,0,0, 0,0,0, 1,0,0,1,0,0), "post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
